// File: rtl/button_events.sv
// Turns five debounced button levels into registered press/release/auto-repeat pulses
// and a lowest-index-wins event view for the menu FSM.
module button_events #(
  parameter int unsigned HOLD_TIME   = 20,
  parameter int unsigned REPEAT_TIME = 5,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] btn_in,
  output logic [4:0] press,
  output logic [4:0] release_pulse, // release pulses; the bare name is a reserved word
  output logic [4:0] rpt,
  output logic [4:0] held,
  output logic       event_valid,
  output logic [2:0] event_code,
  output logic       event_repeat
);

  localparam int unsigned NumBtn = 5;
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TIME - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitHold,
    StRepeat
  } state_e;

  state_e           state_q [NumBtn];
  state_e           state_d [NumBtn];
  logic [CNT_W-1:0] cnt_q   [NumBtn];
  logic [CNT_W-1:0] cnt_d   [NumBtn];

  logic [4:0] press_q, press_d;
  logic [4:0] release_q, release_d;
  logic [4:0] rpt_q, rpt_d;
  logic [4:0] held_q, held_d;
  logic [4:0] ev;

  always_comb begin
    press_d   = '0;
    release_d = '0;
    rpt_d     = '0;
    held_d    = held_q;
    for (int i = 0; i < NumBtn; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // Disable clears everything so a still-held button re-presses on re-enable.
      if (!enable) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
        held_d[i]  = 1'b0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (btn_in[i]) begin
              press_d[i] = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = StWaitHold;
            end
          end
          StWaitHold: begin
            if (!btn_in[i]) begin
              release_d[i] = 1'b1;
              state_d[i]   = StIdle;
            end else if (cnt_q[i] == HoldLast) begin
              rpt_d[i]   = 1'b1;
              held_d[i]  = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = StRepeat;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          StRepeat: begin
            if (!btn_in[i]) begin
              release_d[i] = 1'b1;
              held_d[i]    = 1'b0;
              state_d[i]   = StIdle;
            end else if (cnt_q[i] == RepeatLast) begin
              rpt_d[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            held_d[i]  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
      rpt_q     <= '0;
      held_q    <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign rpt           = rpt_q;
  assign held          = held_q;
  assign ev            = press_q | rpt_q;

  // Scan downward so the lowest set index wins.
  always_comb begin
    event_valid  = |ev;
    event_code   = '0;
    event_repeat = 1'b0;
    for (int i = NumBtn - 1; i >= 0; i--) begin
      if (ev[i]) begin
        event_code   = 3'(i);
        event_repeat = rpt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with HOLD_TIME = 20, REPEAT_TIME = 5; expected
// outputs are written out per cycle relative to the first edge of each scenario.
module tb_button_events;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] btn_in = '0;
  logic [4:0] press, release_pulse, rpt, held;
  logic       event_valid;
  logic [2:0] event_code;
  logic       event_repeat;

  int vectors = 0;
  int miscompares = 0;

  button_events #(
    .HOLD_TIME  (20),
    .REPEAT_TIME(5),
    .CNT_W      (24)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .btn_in       (btn_in),
    .press        (press),
    .release_pulse(release_pulse),
    .rpt          (rpt),
    .held         (held),
    .event_valid  (event_valid),
    .event_code   (event_code),
    .event_repeat (event_repeat)
  );

  always #5 clock = ~clock;

  // {press, release, rpt, held, event_valid, event_code, event_repeat}
  logic [24:0] obs;
  assign obs = {press, release_pulse, rpt, held, event_valid, event_code, event_repeat};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] exp;
    reset  = 1'b1;
    enable = 1'b1;
    btn_in = 5'b11111;
    for (int j = 0; j < 7; j++) begin
      if (j == 3) reset = 1'b0;
      if (j == 5) btn_in = 5'b00000;
      tick();
      exp = '0;
      if (j == 3) exp = {5'b11111, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0};
      if (j == 5) exp = {5'b00000, 5'b11111, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
  endtask

  task automatic test_short_press();
    logic [24:0] exp;
    for (int j = 0; j < 6; j++) begin
      btn_in = (j < 4) ? 5'b00100 : 5'b00000;
      tick();
      exp = '0;
      if (j == 0) exp = {5'b00100, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd2, 1'b0};
      if (j == 4) exp = {5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL short_press j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
  endtask

  task automatic test_long_hold();
    logic [24:0] exp;
    logic [4:0]  p, r, t, h;
    for (int j = 0; j < 42; j++) begin
      btn_in = (j < 40) ? 5'b01000 : 5'b00000;
      tick();
      p = (j == 0) ? 5'b01000 : 5'b00000;
      r = (j == 40) ? 5'b01000 : 5'b00000;
      t = (j == 20 || j == 25 || j == 30 || j == 35) ? 5'b01000 : 5'b00000;
      h = (j >= 20 && j < 40) ? 5'b01000 : 5'b00000;
      exp = {p, r, t, h, |(p | t), (|(p | t)) ? 3'd3 : 3'd0, |t};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL long_hold j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
  endtask

  task automatic test_release_terminal();
    logic [24:0] exp;
    for (int j = 0; j < 22; j++) begin
      btn_in = (j < 20) ? 5'b00010 : 5'b00000;
      tick();
      exp = '0;
      if (j == 0)  exp = {5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd1, 1'b0};
      if (j == 20) exp = {5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL release_terminal j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
  endtask

  task automatic test_priority();
    logic [24:0] exp;
    for (int j = 0; j < 23; j++) begin
      btn_in = {(j < 21), 3'b000, (j < 3)};
      tick();
      exp = '0;
      if (j == 0)  exp = {5'b10001, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0};
      if (j == 3)  exp = {5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (j == 20) exp = {5'b00000, 5'b00000, 5'b10000, 5'b10000, 1'b1, 3'd4, 1'b1};
      if (j == 21) exp = {5'b00000, 5'b10000, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL priority j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
  endtask

  task automatic test_enable_clear();
    logic [24:0] exp;
    for (int j = 0; j < 54; j++) begin
      btn_in = (j <= 51) ? 5'b00001 : 5'b00000;
      enable = !(j >= 21 && j <= 30);
      tick();
      exp = '0;
      if (j == 0 || j == 31)
        exp = {5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0};
      if (j == 20 || j == 51)
        exp = {5'b00000, 5'b00000, 5'b00001, 5'b00001, 1'b1, 3'd0, 1'b1};
      if (j == 52) exp = {5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL enable_clear j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    logic [24:0] exp;
    for (int j = 0; j < 26; j++) begin
      btn_in = (j < 24) ? 5'b00001 : 5'b00000;
      reset  = (j == 21);
      tick();
      exp = '0;
      if (j == 0 || j == 22)
        exp = {5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0};
      if (j == 20) exp = {5'b00000, 5'b00000, 5'b00001, 5'b00001, 1'b1, 3'd0, 1'b1};
      if (j == 24) exp = {5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_hold j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp;
    for (int j = 0; j < 5; j++) begin
      btn_in = (j == 0 || j == 2) ? 5'b01000 : 5'b00000;
      tick();
      exp = '0;
      if (j == 0 || j == 2)
        exp = {5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 3'd3, 1'b0};
      if (j == 1 || j == 3)
        exp = {5'b00000, 5'b01000, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL back_to_back j=%0d got %b want %b", j, obs, exp);
      end
      vectors++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_short_press();
    test_long_hold();
    test_release_terminal();
    test_priority();
    test_enable_clear();
    test_reset_mid_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Converts the five debounced, level-valued button lines into one-clock event pulses for the front-panel control logic of the muon lifetime readout. It sits directly downstream of the button debouncer. Each button gets a press pulse and a release pulse, plus auto-repeat pulses while it is held. A prioritised single-event view feeds the menu/parameter FSM.

## Interface
Parameters:
- HOLD_TIME, default 20: cycles from the press pulse to the first repeat pulse. Must be ≥ 2.
- REPEAT_TIME, default 5: cycles between successive repeat pulses. Must be ≥ 1.
- CNT_W, default 24: per-button counter width. HOLD_TIME and REPEAT_TIME must both be < 2^CNT_W.

Ports:
- clock, input, 1: system clock (100 MHz); all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: block enable.
- btn_in, input, 5: debounced button levels; 1 = pressed.
- press, output, 5: one-cycle pulse per bit on a press.
- release, output, 5: one-cycle pulse per bit on a release.
- rpt, output, 5: one-cycle auto-repeat pulse per bit.
- held, output, 5: level; 1 while the button is in the repeat phase.
- event_valid, output, 1: high when any bit of press or rpt is high.
- event_code, output, 3: index of the lowest-numbered bit set in (press | rpt); 0 when event_valid = 0.
- event_repeat, output, 1: 1 if the event at event_code is a repeat, 0 if it is a press; 0 when event_valid = 0.

## Operation
- Five independent per-button FSMs, each with states IDLE, WAIT_HOLD and REPEAT, and a CNT_W-bit counter cnt.
- press, release, rpt and held are registered. event_* are combinational from those registers and add no latency.
- Every clock where enable = 1, the pulse registers default to 0. Then, per bit i:
  - IDLE, btn_in[i] = 1: press[i] ← 1, cnt ← 0, go to WAIT_HOLD.
  - IDLE, btn_in[i] = 0: no change.
  - WAIT_HOLD, btn_in[i] = 0: release[i] ← 1, go to IDLE.
  - WAIT_HOLD, cnt = HOLD_TIME−1: rpt[i] ← 1, held[i] ← 1, cnt ← 0, go to REPEAT.
  - WAIT_HOLD, otherwise: cnt ← cnt+1.
  - REPEAT, btn_in[i] = 0: release[i] ← 1, held[i] ← 0, go to IDLE.
  - REPEAT, cnt = REPEAT_TIME−1: rpt[i] ← 1, cnt ← 0.
  - REPEAT, otherwise: cnt ← cnt+1.
- Release has priority over the terminal count. If btn_in drops on the cycle the count expires, only release fires.
- Bits are fully independent. Simultaneous presses on several buttons produce simultaneous press bits. event_code reports the lowest index; higher-index events on that cycle remain visible only on press/rpt.
- enable = 0 behaves as a clear, not a freeze:
  - All FSMs go to IDLE, counters go to 0, and all outputs go to 0.
  - No release pulses are emitted while disabled.
  - On re-enable, any button still held produces a fresh press pulse on the first enabled clock.
- reset = 1 has the same effect as enable = 0 and has priority over enable. Reset mid-hold discards the hold with no release pulse.
- reset values: press = release = rpt = held = 0, event_valid = 0, event_code = 0, event_repeat = 0, all states IDLE, all cnt = 0.

## Timing
- Edge k is the first rising edge at which btn_in[i] = 1 is sampled with the FSM in IDLE.
- press[i] is high for exactly the one cycle following edge k.
- The first rpt[i] is high for the one cycle following edge k+HOLD_TIME, i.e. HOLD_TIME cycles after the press pulse. held[i] rises in the same cycle.
- Subsequent rpt[i] pulses are spaced exactly REPEAT_TIME cycles apart. With REPEAT_TIME = 1, rpt[i] stays high continuously.
- release[i] is high for the one cycle after the first edge that samples btn_in[i] = 0. held[i] falls in that same cycle.
- Minimum press: 1 cycle high, giving a press pulse followed immediately by a release pulse in the next cycle.
- A re-press on the cycle after a release restarts from IDLE with a new press pulse. No pulses are lost.

## Test plan
Defaults HOLD_TIME = 20, REPEAT_TIME = 5 unless stated.
- Reset: assert reset for 3 cycles with btn_in = 5'b11111 → all outputs 0 throughout. After reset drops with enable = 1, all five press bits pulse together; event_code = 0, event_repeat = 0.
- Short press: btn_in[2] high for 4 cycles → press = 5'b00100 for 1 cycle; 4 cycles later release = 5'b00100 for 1 cycle; no rpt; held stays 0.
- Long hold: btn_in[3] high for 40 cycles → press at t; rpt at t+20, t+25, t+30, t+35; held[3] high from t+20 until the release pulse at t+40; event_code = 3, event_repeat = 1 on each rpt cycle.
- Release at terminal count: btn_in[1] drops exactly on the edge where cnt = 19 → release fires, rpt does not fire, held stays 0.
- Priority: btn_in[4] and btn_in[0] rise on the same edge → press = 5'b10001, event_code = 0. Then btn_in[0] drops → on the next rpt of bit 4, event_code = 4.
- Enable clear: hold btn_in[0], deassert enable for 10 cycles after the first rpt, then reassert → outputs are 0 while disabled with no release pulse; on re-enable press[0] pulses once and the next rpt follows HOLD_TIME cycles later.
